// File: rtl/bsg_manycore_npa_to_eva.sv
// bsg_manycore_npa_to_eva: maps a global NPA back to the byte EVA a vanilla
// core would issue; two-stage valid/ready pipe with an invalid-result counter.
module bsg_manycore_npa_to_eva #(
  parameter int addr_width_p = 28,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7,
  parameter int pod_x_cord_width_p = 3,
  parameter int pod_y_cord_width_p = 4,
  parameter int num_tiles_x_p = 16,
  parameter int num_tiles_y_p = 8,
  parameter int num_vcache_rows_p = 1,
  parameter int vcache_block_size_in_words_p = 8,
  parameter int err_cnt_width_p = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic [pod_x_cord_width_p-1:0] pod_x_i,
  input  logic [pod_y_cord_width_p-1:0] pod_y_i,
  input  logic v_i,
  input  logic [x_cord_width_p-1:0] x_cord_i,
  input  logic [y_cord_width_p-1:0] y_cord_i,
  input  logic [addr_width_p-1:0] epa_i,
  output logic ready_o,
  output logic v_o,
  output logic [31:0] eva_o,
  output logic is_dram_o,
  output logic is_invalid_o,
  input  logic yumi_i,
  output logic [err_cnt_width_p-1:0] err_count_o
);

  localparam int x_sub_w_lp = $clog2(num_tiles_x_p);
  localparam int y_sub_w_lp = $clog2(num_tiles_y_p);
  localparam int row_w_lp = $clog2(2*num_vcache_rows_p);
  localparam int off_w_lp = $clog2(vcache_block_size_in_words_p);
  // EPA bits that still fit once row and x_sub are spliced into the word
  localparam int keep_w_lp = 29 - row_w_lp - x_sub_w_lp;
  localparam int word_w_lp = addr_width_p + row_w_lp + x_sub_w_lp;

  typedef enum logic [1:0] {
    k_inv,
    k_tile,
    k_dram
  } kind_e;

  logic [pod_x_cord_width_p-1:0] pod_x;
  logic [pod_y_cord_width_p-1:0] pod_y;
  logic [pod_y_cord_width_p-1:0] pod_y_n;
  logic [pod_y_cord_width_p-1:0] pod_y_s;
  logic [x_sub_w_lp-1:0] x_sub;
  logic [y_sub_w_lp-1:0] y_sub;

  assign pod_x = x_cord_i[x_cord_width_p-1-:pod_x_cord_width_p];
  assign x_sub = x_cord_i[x_sub_w_lp-1:0];
  assign pod_y = y_cord_i[y_cord_width_p-1-:pod_y_cord_width_p];
  assign y_sub = y_cord_i[y_sub_w_lp-1:0];
  assign pod_y_n = pod_y_i - pod_y_cord_width_p'(1);
  assign pod_y_s = pod_y_i + pod_y_cord_width_p'(1);

  logic tile_hit, n_hit, s_hit;
  logic tile_bad, dram_bad;
  logic [row_w_lp-1:0] n_row, s_row;

  assign tile_hit = (pod_y == pod_y_i);
  assign tile_bad = ((epa_i >> 14) != '0)
                 || ((x_cord_i >> 7) != '0)
                 || ((y_cord_i >> 7) != '0);
  assign dram_bad = (epa_i >> keep_w_lp) != '0;

  always_comb begin
    n_hit = 1'b0;
    s_hit = 1'b0;
    n_row = '0;
    s_row = '0;
    for (int k = 0; k < num_vcache_rows_p; k++) begin
      if (y_sub == y_sub_w_lp'(num_tiles_y_p-1-k)) begin
        n_hit = 1'b1;
        n_row = row_w_lp'(2*k);
      end
      if (y_sub == y_sub_w_lp'(k)) begin
        s_hit = 1'b1;
        s_row = row_w_lp'(2*k+1);
      end
    end
    n_hit = n_hit && (pod_y == pod_y_n) && (pod_x == pod_x_i);
    s_hit = s_hit && (pod_y == pod_y_s) && (pod_x == pod_x_i);
  end

  kind_e kind_d;
  logic [row_w_lp-1:0] row_d;

  always_comb begin
    kind_d = k_inv;
    row_d = '0;
    unique case (1'b1)
      tile_hit: kind_d = tile_bad ? k_inv : k_tile;
      n_hit: begin
        kind_d = dram_bad ? k_inv : k_dram;
        row_d = n_row;
      end
      s_hit: begin
        kind_d = dram_bad ? k_inv : k_dram;
        row_d = s_row;
      end
      default: ;
    endcase
  end

  logic s1_v, s2_v, s2_adv;
  kind_e s1_kind;
  logic [row_w_lp-1:0] s1_row;
  logic [x_sub_w_lp-1:0] s1_x_sub;
  logic [6:0] s1_x, s1_y;
  logic [addr_width_p-1:0] s1_epa;

  logic [word_w_lp-1:0] dram_word;
  logic [31:0] eva_d;
  logic [31:0] eva_r;
  logic dram_r, inv_r;
  logic [err_cnt_width_p-1:0] err_cnt_r;

  assign s2_adv = !s2_v || yumi_i;
  assign ready_o = !s1_v || s2_adv;

  assign dram_word = {s1_epa[addr_width_p-1:off_w_lp], s1_row,
                      s1_x_sub, s1_epa[off_w_lp-1:0]};

  always_comb begin
    eva_d = '0;
    unique case (s1_kind)
      k_tile: eva_d = {2'b01, s1_y, s1_x, s1_epa[13:0], 2'b00};
      k_dram: eva_d = {1'b1, 29'(dram_word), 2'b00};
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      s1_v <= 1'b0;
      s1_kind <= k_inv;
      s1_row <= '0;
      s1_x_sub <= '0;
      s1_x <= '0;
      s1_y <= '0;
      s1_epa <= '0;
      s2_v <= 1'b0;
      eva_r <= '0;
      dram_r <= 1'b0;
      inv_r <= 1'b0;
      err_cnt_r <= '0;
    end else begin
      if (ready_o) begin
        s1_v <= v_i;
        if (v_i) begin
          s1_kind <= kind_d;
          s1_row <= row_d;
          s1_x_sub <= x_sub;
          s1_x <= 7'(x_cord_i);
          s1_y <= 7'(y_cord_i);
          s1_epa <= epa_i;
        end
      end
      if (s2_adv) begin
        s2_v <= s1_v;
        if (s1_v) begin
          eva_r <= eva_d;
          dram_r <= (s1_kind == k_dram);
          inv_r <= (s1_kind == k_inv);
        end
      end
      if (yumi_i && s2_v && inv_r && !(&err_cnt_r))
        err_cnt_r <= err_cnt_r + 1'b1;
    end
  end

  assign v_o = s2_v;
  assign eva_o = eva_r;
  assign is_dram_o = dram_r;
  assign is_invalid_o = inv_r;
  assign err_count_o = err_cnt_r;

  always @(posedge clk_i) begin
    if (reset_i && yumi_i) assert (s2_v);
  end

endmodule

// File: tb/tb_bsg_manycore_npa_to_eva.sv
// Bench for bsg_manycore_npa_to_eva: directed table, random scoreboard
// against an arithmetic reference, backpressure, saturation and reset.
module tb_bsg_manycore_npa_to_eva;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_i, v_i, yumi_i;
  logic ready_o, v_o, is_dram_o, is_invalid_o;
  logic [2:0] pod_x_i;
  logic [3:0] pod_y_i;
  logic [6:0] x_cord_i, y_cord_i;
  logic [27:0] epa_i;
  logic [31:0] eva_o;
  logic [15:0] err_count_o;

  bsg_manycore_npa_to_eva dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .pod_x_i(pod_x_i),
    .pod_y_i(pod_y_i),
    .v_i(v_i),
    .x_cord_i(x_cord_i),
    .y_cord_i(y_cord_i),
    .epa_i(epa_i),
    .ready_o(ready_o),
    .v_o(v_o),
    .eva_o(eva_o),
    .is_dram_o(is_dram_o),
    .is_invalid_o(is_invalid_o),
    .yumi_i(yumi_i),
    .err_count_o(err_count_o)
  );

  typedef struct {
    logic [31:0] eva;
    bit dram;
    bit inv;
    int cyc;
  } exp_t;

  typedef struct {
    logic [2:0] px;
    logic [3:0] py;
    logic [6:0] x;
    logic [6:0] y;
    logic [27:0] epa;
    logic [31:0] eva;
    bit dram;
    bit inv;
  } vec_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pops = 0;
  int last_pop = 0;
  bit chk_lat = 1'b0;
  logic [15:0] model_err = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  // Reference: spec rules in plain integer arithmetic
  function automatic exp_t model(input logic [6:0] x, input logic [6:0] y,
                                 input logic [27:0] epa);
    exp_t r;
    int px, xs, py, ys, row;
    longint a, w;
    r = '{eva: 32'd0, dram: 1'b0, inv: 1'b0, cyc: 0};
    px = int'(x) / 16;
    xs = int'(x) % 16;
    py = int'(y) / 8;
    ys = int'(y) % 8;
    a = longint'(epa);
    row = -1;
    if (py == int'(pod_y_i)) begin
      if (a < 16384) begin
        w = 64'h4000_0000 + longint'(y) * (1 << 23)
          + longint'(x) * (1 << 16) + a * 4;
        r.eva = 32'(w);
      end else r.inv = 1'b1;
      return r;
    end
    if (px == int'(pod_x_i) && py == (int'(pod_y_i) + 15) % 16 && ys == 7)
      row = 0;
    else if (px == int'(pod_x_i) && py == (int'(pod_y_i) + 1) % 16 && ys == 0)
      row = 1;
    if (row < 0) begin
      r.inv = 1'b1;
      return r;
    end
    w = (a / 8) * 256 + longint'(row) * 128 + longint'(xs) * 8 + a % 8;
    if (w >= (longint'(1) << 29)) r.inv = 1'b1;
    else begin
      r.dram = 1'b1;
      r.eva = 32'(64'h8000_0000 + w * 4);
    end
    return r;
  endfunction

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      chk("spurious_v_o", 64'(v_o), 64'd0);
      return;
    end
    e = sb.pop_front();
    chk("eva", 64'(eva_o), 64'(e.eva));
    chk("is_dram", 64'(is_dram_o), 64'(e.dram));
    chk("is_invalid", 64'(is_invalid_o), 64'(e.inv));
    chk("err_count", 64'(err_count_o), 64'(model_err));
    if (chk_lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
    if (e.inv && model_err != 16'hFFFF) model_err++;
    pops++;
    last_pop = cyc;
  endtask

  task automatic cycle(input bit tv, input bit ty, input logic [6:0] x,
                       input logic [6:0] y, input logic [27:0] e,
                       input exp_t ex, output bit acc);
    @(negedge clk);
    cyc++;
    yumi_i = ty && v_o;
    if (yumi_i) check_pop();
    #1;
    v_i = tv;
    x_cord_i = x;
    y_cord_i = y;
    epa_i = e;
    acc = tv && ready_o;
    if (acc) begin
      ex.cyc = cyc;
      sb.push_back(ex);
    end
  endtask

  task automatic idle(input bit ty);
    bit a;
    exp_t z;
    z = '{eva: 32'd0, dram: 1'b0, inv: 1'b0, cyc: 0};
    cycle(1'b0, ty, 7'd0, 7'd0, 28'd0, z, a);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      idle(1'b1);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic rand_req(output logic [6:0] x, output logic [6:0] y,
                          output logic [27:0] e);
    int s;
    logic [3:0] py;
    logic [2:0] ys, px;
    s = $urandom_range(0, 3);
    case (s)
      0: py = pod_y_i;
      1: py = 4'(pod_y_i - 4'd1);
      2: py = 4'(pod_y_i + 4'd1);
      default: py = 4'($urandom);
    endcase
    ys = 3'($urandom);
    if ($urandom_range(0, 2) != 0) ys = (s == 1) ? 3'd7 : 3'd0;
    px = ($urandom_range(0, 3) != 0) ? pod_x_i : 3'($urandom);
    x = {px, 4'($urandom)};
    y = {py, ys};
    case ($urandom_range(0, 3))
      0: e = 28'($urandom) & 28'h000_3FFF;
      1: e = 28'($urandom) & 28'h0FF_FFFF;
      default: e = 28'($urandom);
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b0;
    v_i = 1'b0;
    yumi_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b1;
    sb.delete();
    model_err = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_v_o"}, 64'(v_o), 64'd0);
    chk({tag, "_eva"}, 64'(eva_o), 64'd0);
    chk({tag, "_dram"}, 64'(is_dram_o), 64'd0);
    chk({tag, "_inv"}, 64'(is_invalid_o), 64'd0);
    chk({tag, "_err"}, 64'(err_count_o), 64'd0);
    chk({tag, "_ready"}, 64'(ready_o), 64'd1);
  endtask

  vec_t tbl[13];

  initial begin
    bit a;
    int sent, n, p0, first, need;
    logic [6:0] x, y;
    logic [27:0] e;
    exp_t ex;

    tbl[0]  = '{3'd1, 4'd1,  7'h15, 7'h07, 28'h12, 32'h8000_08A8, 1'b1, 1'b0};
    tbl[1]  = '{3'd1, 4'd1,  7'h15, 7'h10, 28'h12, 32'h8000_0AA8, 1'b1, 1'b0};
    tbl[2]  = '{3'd1, 4'd1,  7'h15, 7'h09, 28'h100, 32'h4495_0400, 1'b0, 1'b0};
    tbl[3]  = '{3'd1, 4'd1,  7'h15, 7'h07, 28'h100_0000, 32'h0, 1'b0, 1'b1};
    tbl[4]  = '{3'd1, 4'd1,  7'h15, 7'h1C, 28'h12, 32'h0, 1'b0, 1'b1};
    tbl[5]  = '{3'd1, 4'd1,  7'h15, 7'h09, 28'h4000, 32'h0, 1'b0, 1'b1};
    tbl[6]  = '{3'd1, 4'd1,  7'h00, 7'h08, 28'h3FFF, 32'h4400_FFFC, 1'b0, 1'b0};
    tbl[7]  = '{3'd1, 4'd1,  7'h15, 7'h07, 28'hFF_FFFF, 32'hFFFF_FCBC, 1'b1, 1'b0};
    tbl[8]  = '{3'd1, 4'd1,  7'h25, 7'h07, 28'h12, 32'h0, 1'b0, 1'b1};
    tbl[9]  = '{3'd1, 4'd1,  7'h15, 7'h06, 28'h12, 32'h0, 1'b0, 1'b1};
    tbl[10] = '{3'd1, 4'd0,  7'h15, 7'h7F, 28'h12, 32'h8000_08A8, 1'b1, 1'b0};
    tbl[11] = '{3'd1, 4'd15, 7'h15, 7'h00, 28'h12, 32'h8000_0AA8, 1'b1, 1'b0};
    tbl[12] = '{3'd1, 4'd0,  7'h7F, 7'h03, 28'h1, 32'h41FF_0004, 1'b0, 1'b0};

    reset_i = 1'b0;
    v_i = 1'b0;
    yumi_i = 1'b0;
    pod_x_i = 3'd1;
    pod_y_i = 4'd1;
    x_cord_i = '0;
    y_cord_i = '0;
    epa_i = '0;
    repeat (2) @(negedge clk);
    do_reset();
    chk_reset("reset");

    chk_lat = 1'b1;
    foreach (tbl[i]) begin
      pod_x_i = tbl[i].px;
      pod_y_i = tbl[i].py;
      ex = '{eva: tbl[i].eva, dram: tbl[i].dram, inv: tbl[i].inv, cyc: 0};
      cycle(1'b1, 1'b0, tbl[i].x, tbl[i].y, tbl[i].epa, ex, a);
      chk("accept", 64'(a), 64'd1);
      drain(10);
    end
    chk_lat = 1'b0;

    for (int b = 0; b < 4; b++) begin
      pod_x_i = 3'($urandom);
      pod_y_i = 4'($urandom);
      sent = 0;
      n = 0;
      while (sent < 150 && n < 2000) begin
        rand_req(x, y, e);
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
              x, y, e, model(x, y, e), a);
        if (a) sent++;
        n++;
      end
      drain(20);
    end

    pod_x_i = 3'd1;
    pod_y_i = 4'd1;
    sent = 0;
    for (int c = 0; c < 5; c++) begin
      rand_req(x, y, e);
      cycle(sent < 8, 1'b0, x, y, e, model(x, y, e), a);
      if (a) sent++;
    end
    chk("bp_accepted", 64'(sent), 64'd2);
    chk("bp_ready_low", 64'(ready_o), 64'd0);
    chk("bp_v_o_held", 64'(v_o), 64'd1);
    p0 = pops;
    first = -1;
    n = 0;
    while ((sent < 8 || sb.size() != 0) && n < 40) begin
      rand_req(x, y, e);
      cycle(sent < 8, 1'b1, x, y, e, model(x, y, e), a);
      if (a) sent++;
      if (first < 0 && pops > p0) first = last_pop;
      n++;
    end
    chk("bp_all_out", 64'(pops - p0), 64'd8);
    chk("bp_rate", 64'(last_pop - first), 64'd7);

    need = 32'hFFFE - int'(model_err);
    sent = 0;
    n = 0;
    while (sent < need && n < 70000) begin
      cycle(1'b1, 1'b1, 7'h15, 7'h1C, 28'h12, model(7'h15, 7'h1C, 28'h12), a);
      if (a) sent++;
      n++;
    end
    drain(10);
    idle(1'b0);
    chk("err_at_fffe", 64'(err_count_o), 64'hFFFE);
    sent = 0;
    n = 0;
    while (sent < 3 && n < 20) begin
      cycle(1'b1, 1'b1, 7'h15, 7'h1C, 28'h12, model(7'h15, 7'h1C, 28'h12), a);
      if (a) sent++;
      n++;
    end
    drain(10);
    idle(1'b0);
    chk("err_saturated", 64'(err_count_o), 64'hFFFF);

    cycle(1'b1, 1'b0, 7'h15, 7'h07, 28'h12, model(7'h15, 7'h07, 28'h12), a);
    cycle(1'b1, 1'b0, 7'h15, 7'h10, 28'h12, model(7'h15, 7'h10, 28'h12), a);
    do_reset();
    chk_reset("midreset");
    chk_lat = 1'b1;
    ex = '{eva: 32'h4495_0400, dram: 1'b0, inv: 1'b0, cyc: 0};
    cycle(1'b1, 1'b0, 7'h15, 7'h09, 28'h100, ex, a);
    chk("post_reset_accept", 64'(a), 64'd1);
    drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bsg_manycore_npa_to_eva.md
Name: bsg_manycore_npa_to_eva

Overview:
- Inverse translator: takes an NPA (global x/y cord plus word EPA) and returns the 32-bit byte EVA that a vanilla core would issue to reach it.
- Covers the DRAM-striped vcache space and the global space. Tile-group EVAs are never produced.
- Sits on the endpoint/host side: trace, profiler and DMA-descriptor paths use it to report or replay accesses in EVA form.
- 2-stage valid/ready pipeline; counts untranslatable requests.

Parameters:
- addr_width_p, 28, EPA word-address width.
- x_cord_width_p, 7, global x cord width.
- y_cord_width_p, 7, global y cord width.
- pod_x_cord_width_p, 3, pod x width.
- pod_y_cord_width_p, 4, pod y width.
- num_tiles_x_p, 16, tiles per pod in x; x_sub width = clog2 = 4.
- num_tiles_y_p, 8, tiles per pod in y; y_sub width = clog2 = 3.
- num_vcache_rows_p, 1, vcache layers per side; row-id width = clog2(2*rows).
- vcache_block_size_in_words_p, 8, stripe granularity; offset width = clog2 = 3.
- err_cnt_width_p, 16, invalid counter width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk_i).
- pod_x_i  in  pod_x_cord_width_p  pod of the tile array being decoded; quasi-static.
- pod_y_i  in  pod_y_cord_width_p  as above.
- v_i  in  1  request valid.
- x_cord_i  in  x_cord_width_p  destination x cord.
- y_cord_i  in  y_cord_width_p  destination y cord.
- epa_i  in  addr_width_p  destination word EPA.
- ready_o  out  1  can accept.
- v_o  out  1  result valid.
- eva_o  out  32  reconstructed byte EVA.
- is_dram_o  out  1  eva_o is DRAM space.
- is_invalid_o  out  1  NPA has no EVA; eva_o = 0.
- yumi_i  in  1  consumer takes result; legal only when v_o = 1.
- err_count_o  out  err_cnt_width_p  saturating count of invalid results consumed.

Behaviour:
- Decode cords: pod_x = x_cord_i[MSBs], x_sub = LSBs; pod_y and y_sub likewise.
- Classification (stage 1, registered). The first matching rule applies:
  - Tile, if pod_y == pod_y_i: global EVA.
    - eva[31:30] = 01, [29:23] = y_cord, [22:16] = x_cord, [15:2] = epa[13:0], [1:0] = 0.
    - Invalid if epa_i[addr_width_p-1:14] != 0, or a cord is wider than 7 bits with nonzero excess.
  - North vcache, if pod_y == pod_y_i-1, pod_x == pod_x_i, and y_sub = num_tiles_y_p-1-k for k < num_vcache_rows_p: row r = 2k.
  - South vcache, if pod_y == pod_y_i+1, pod_x == pod_x_i, and y_sub = k for k < num_vcache_rows_p: row r = 2k+1.
  - DRAM EVA: word = {epa[hi:off_w], r, x_sub, epa[off_w-1:0]} truncated to 29 bits; eva = {1'b1, word, 2'b00}.
    - Invalid if any EPA bit above the 29-bit word field is set.
  - Anything else: invalid.
- pod_y_i ± 1 arithmetic wraps modulo 2^pod_y_cord_width_p. No special case at pod 0 or max.
- Pipeline: stage 1 registers the decoded fields; stage 2 registers the composed EVA and flags.
  - Latency is 2 cycles from v_i&&ready_o to v_o under no backpressure.
  - Throughput is 1 per cycle.
- Handshake:
  - ready_o = !s1_v || (!s2_v || yumi_i). Full stall propagation, no bubble when draining.
  - Outputs stay stable while v_o && !yumi_i.
  - Accept and yumi in the same cycle are both honoured.
  - Order is preserved.
- err_count_o increments on yumi_i && is_invalid_o and saturates at all-ones.
- Reset (including mid-flight): both stage valids clear, v_o = 0, eva_o = 0, is_dram_o = 0, is_invalid_o = 0, err_count_o = 0, ready_o = 1 on the first cycle after reset. Pending entries are dropped.
- yumi_i with v_o = 0 is ignored. A sim-only assertion flags it.

Test Plan:
- DRAM north (defaults, pod_x_i = 1, pod_y_i = 1): x_cord = 0x15, y_cord = 7, epa = 0x12 -> v_o 2 cycles later, eva_o = 0x8000_08A8, is_dram_o = 1.
- DRAM south: same as above but y_cord = 16 (pod_y 2, y_sub 0) -> eva_o = 0x8000_0AA8.
- Global tile: x_cord = 0x15, y_cord = 0x09, epa = 0x100 -> eva_o = 0x4495_0400, is_dram_o = 0.
- Invalid cases: north vcache with epa = 0x100_0000 (bit 24 set); and y_cord with pod_y = 3 -> is_invalid_o = 1, eva_o = 0, err_count_o +1 per yumi. Force counter to 0xFFFE, consume 3 invalids -> holds at 0xFFFF.
- Backpressure: stream 8 back-to-back requests, yumi_i low for 5 cycles -> ready_o drops after 2 are held; all 8 results arrive in order, none lost or duplicated. With yumi_i held high, 1 result per cycle.
- Reset mid-operation: 2 entries in flight, reset_i = 0 for 1 cycle -> v_o = 0 next cycle, err_count_o = 0, ready_o = 1; the next request completes normally.
